// File: rtl/gzip_ctrl_pkg.sv
// Shared types and constants for the gzip job sequencer: FSM states,
// status error-bit positions and block type encodings.
package gzip_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_CFG    = 3'd2,
        ST_FEED   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_REPORT = 3'd5
    } state_e;

    localparam int ERR_ABORT   = 3;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_BTYPE   = 1;
    localparam int ERR_BLKSZ   = 0;

    localparam logic [1:0] BTYPE_STORED = 2'b00;
    localparam logic [1:0] BTYPE_FIXED  = 2'b01;

endpackage

// File: rtl/gzip_job_sequencer.sv
// Runs one gzip_top job at a time: reset/configure the core, forward exactly
// N input words, wait for done (or timeout/abort), then hold a status record.
module gzip_job_sequencer
    import gzip_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int WORDS_W        = 24
) (
    input  logic               core_clock,
    input  logic               bus_reset,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [1:0]         desc_btype,
    input  logic               desc_rev_endian,
    input  logic [WORDS_W-1:0] desc_words,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               core_in_full,
    output logic               core_in_wren,
    output logic               core_rst_n,
    output logic [1:0]         core_btype,
    output logic               core_rev_endian,
    input  logic [2:0]         core_status,
    input  logic [31:0]        core_isize,
    input  logic [31:0]        core_crc,
    input  logic [23:0]        core_out_bits,
    output logic               sts_valid,
    input  logic               sts_ready,
    output logic [3:0]         sts_err,
    output logic [31:0]        sts_isize,
    output logic [31:0]        sts_crc,
    output logic [23:0]        sts_out_bits,
    output logic               busy,
    output logic               irq
);

    localparam int TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYCLES - 1);

    state_e             state_q, state_d;
    logic [WORDS_W-1:0] words_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [RCNT_W-1:0]  rcnt_q;
    logic               desc_ready_q;
    logic               core_rst_n_q;
    logic [1:0]         core_btype_q;
    logic               core_rev_q;
    logic               sts_valid_q;
    logic [3:0]         sts_err_q, err_d;
    logic [31:0]        sts_isize_q, sts_crc_q;
    logic [23:0]        sts_out_bits_q;
    logic               cap_d;
    logic               feed_xfer, in_job, accept;

    assign feed_xfer = (state_q == ST_FEED) && in_valid && !core_in_full;
    assign in_job    = (state_q == ST_RST) || (state_q == ST_CFG) ||
                       (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign accept    = (state_q == ST_IDLE) && desc_valid && desc_ready_q;

    always_comb begin
        state_d = state_q;
        cap_d   = 1'b0;
        err_d   = 4'b0;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_RST;
            ST_RST:    if (rcnt_q == RST_LAST) state_d = ST_CFG;
            ST_CFG:    state_d = (words_q != '0) ? ST_FEED : ST_DRAIN;
            ST_FEED:   if (feed_xfer && words_q == WORDS_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // done beats a same-cycle timeout
                if (core_status[2]) begin
                    cap_d = 1'b1;
                    err_d[ERR_BTYPE] = core_status[1];
                    err_d[ERR_BLKSZ] = core_status[0];
                end else if (tmr_q == TMR_LAST) begin
                    cap_d = 1'b1;
                    err_d[ERR_TIMEOUT] = 1'b1;
                    err_d[ERR_BTYPE]   = core_status[1];
                    err_d[ERR_BLKSZ]   = core_status[0];
                end
            end
            ST_REPORT: if (sts_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort && in_job) begin
            cap_d = 1'b1;
            err_d = 4'b0;
            err_d[ERR_ABORT] = 1'b1;
            err_d[ERR_BTYPE] = core_status[1];
            err_d[ERR_BLKSZ] = core_status[0];
        end
        if (cap_d) state_d = ST_REPORT;
    end

    always_ff @(posedge core_clock) begin
        if (bus_reset) begin
            state_q        <= ST_IDLE;
            words_q        <= '0;
            tmr_q          <= '0;
            rcnt_q         <= '0;
            desc_ready_q   <= 1'b0;
            core_rst_n_q   <= 1'b0;
            core_btype_q   <= 2'b0;
            core_rev_q     <= 1'b0;
            sts_valid_q    <= 1'b0;
            sts_err_q      <= 4'b0;
            sts_isize_q    <= 32'b0;
            sts_crc_q      <= 32'b0;
            sts_out_bits_q <= 24'b0;
        end else begin
            state_q      <= state_d;
            desc_ready_q <= (state_d == ST_IDLE);
            // the core stays out of reset through REPORT only if it was released
            unique case (state_d)
                ST_CFG, ST_FEED, ST_DRAIN: core_rst_n_q <= 1'b1;
                ST_REPORT:                 core_rst_n_q <= core_rst_n_q;
                default:                   core_rst_n_q <= 1'b0;
            endcase
            if (accept) begin
                core_btype_q <= desc_btype;
                core_rev_q   <= desc_rev_endian;
                words_q      <= desc_words;
                rcnt_q       <= '0;
            end else if (state_q == ST_RST) begin
                rcnt_q <= rcnt_q + RCNT_W'(1);
            end
            if (feed_xfer) words_q <= words_q - WORDS_W'(1);
            if (state_q != ST_DRAIN) tmr_q <= '0;
            else                     tmr_q <= tmr_q + TMR_W'(1);
            if (cap_d) begin
                sts_valid_q    <= 1'b1;
                sts_err_q      <= err_d;
                sts_isize_q    <= core_isize;
                sts_crc_q      <= core_crc;
                sts_out_bits_q <= core_out_bits;
            end else if (state_q == ST_REPORT && sts_ready) begin
                sts_valid_q <= 1'b0;
            end
        end
    end

    assign desc_ready      = desc_ready_q;
    assign in_ready        = feed_xfer;
    assign core_in_wren    = feed_xfer;
    assign core_rst_n      = core_rst_n_q;
    assign core_btype      = core_btype_q;
    assign core_rev_endian = core_rev_q;
    assign sts_valid       = sts_valid_q;
    assign sts_err         = sts_err_q;
    assign sts_isize       = sts_isize_q;
    assign sts_crc         = sts_crc_q;
    assign sts_out_bits    = sts_out_bits_q;
    assign busy            = (state_q != ST_IDLE);
    assign irq             = sts_valid_q;

endmodule

// File: tb/tb_gzip_job_sequencer.sv
// Directed bench for gzip_job_sequencer: a table of whole jobs plus
// hand-written abort, reset-mid-drain and idle-abort sequences.
module tb_gzip_job_sequencer;
    import gzip_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        bus_reset, desc_valid, desc_ready, desc_rev_endian, abort;
    logic [1:0]  desc_btype, core_btype;
    logic [23:0] desc_words;
    logic        in_valid, in_ready, core_in_full, core_in_wren, core_rst_n, core_rev_endian;
    logic [2:0]  core_status;
    logic [31:0] core_isize, core_crc, sts_isize, sts_crc;
    logic [23:0] core_out_bits, sts_out_bits;
    logic        sts_valid, sts_ready, busy, irq;
    logic [3:0]  sts_err;

    int nvec = 0;
    int errs = 0;
    int writes = 0;
    int viol = 0;

    always #5 clk = ~clk;

    gzip_job_sequencer #(.RST_CYCLES(4), .TIMEOUT_CYCLES(8), .WORDS_W(24)) dut (
        .core_clock(clk), .bus_reset(bus_reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_btype(desc_btype),
        .desc_rev_endian(desc_rev_endian), .desc_words(desc_words), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .core_in_full(core_in_full),
        .core_in_wren(core_in_wren), .core_rst_n(core_rst_n), .core_btype(core_btype),
        .core_rev_endian(core_rev_endian), .core_status(core_status),
        .core_isize(core_isize), .core_crc(core_crc), .core_out_bits(core_out_bits),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_err(sts_err),
        .sts_isize(sts_isize), .sts_crc(sts_crc), .sts_out_bits(sts_out_bits),
        .busy(busy), .irq(irq)
    );

    // Inputs change just after posedge, so negedge sees what the next edge consumes.
    always @(negedge clk) begin
        if (core_in_wren) writes++;
        if ((core_in_wren !== in_ready) || (core_in_wren && core_in_full) ||
            (in_ready && !in_valid)) viol++;
    end

    typedef struct {
        logic [1:0] btype;
        logic       rev;
        int         words;
        bit         toggle;
        int         done_dly;   // <0: core never finishes
        logic [1:0] core_err;
        logic [3:0] exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start_job(input logic [1:0] bt, input logic rv, input int nw, output int wb);
        int c;
        in_valid = 1'b1;
        core_in_full = 1'b0;
        chk("idle_desc_ready", 64'(desc_ready), 64'd1);
        desc_btype = bt;
        desc_rev_endian = rv;
        desc_words = 24'(nw);
        desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
        wb = writes;
        chk("rst_cfg_fields", 64'({core_btype, core_rev_endian}), 64'({bt, rv}));
        c = 0;
        while (!core_rst_n && c < 20) begin
            c++;
            tick();
        end
        chk("rst_low_cycles", 64'(c), 64'd4);
    endtask

    task automatic feed_until(input int wb, input int target, input bit toggle);
        int c;
        c = 0;
        while ((writes - wb) < target && c < target * 3 + 10) begin
            core_in_full = toggle && (c % 2 == 1);
            c++;
            tick();
        end
        core_in_full = 1'b0;
        chk("feed_bound", 64'(writes - wb), 64'(target));
    endtask

    task automatic wait_sts(output int c);
        c = 0;
        while (!sts_valid && c < 20) begin
            c++;
            tick();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int wb, vb, c;
        logic [31:0] ei, ec;
        logic [23:0] eo;
        ei = 32'h0000_1000 + 32'(v.words);
        ec = 32'hC0DE_0000 ^ {30'(v.words), v.core_err};
        eo = 24'(v.words * 77);
        core_isize = ei;
        core_crc = ec;
        core_out_bits = eo;
        vb = viol;
        start_job(v.btype, v.rev, v.words, wb);
        feed_until(wb, v.words, v.toggle);
        if (v.done_dly < 0) begin
            core_status = {1'b0, v.core_err};
            wait_sts(c);
            chk("timeout_latency", 64'(c), 64'd8);
        end else begin
            repeat (v.done_dly) tick();
            core_status = {1'b1, v.core_err};
            wait_sts(c);
        end
        chk("sts_valid_irq", 64'({sts_valid, irq}), 64'b11);
        chk("sts_err", 64'(sts_err), 64'(v.exp_err));
        chk("sts_results", {sts_isize, sts_crc}, {ei, ec});
        chk("sts_out_bits", 64'(sts_out_bits), 64'(eo));
        chk("total_writes", 64'(writes - wb), 64'(v.words));
        chk("handshake_rules", 64'(viol - vb), 64'd0);
        core_status = 3'b0;
        core_isize = 32'hDEAD_BEEF;
        core_crc = 32'h0;
        repeat (3) tick();
        chk("report_hold", {sts_valid, sts_err, 27'd0, sts_isize}, {1'b1, v.exp_err, 27'd0, ei});
        sts_ready = 1'b1;
        tick();
        sts_ready = 1'b0;
        chk("release", 64'({sts_valid, irq, busy, desc_ready, core_rst_n}), 64'b00010);
    endtask

    initial begin
        int wb, c;
        logic [31:0] ai;
        vecs[0] = '{BTYPE_FIXED,  1'b0, 16, 1'b0,  2, 2'b00, 4'b0000};
        vecs[1] = '{BTYPE_STORED, 1'b1,  5, 1'b1,  1, 2'b00, 4'b0000};
        vecs[2] = '{BTYPE_FIXED,  1'b0,  0, 1'b0,  0, 2'b00, 4'b0000};
        vecs[3] = '{2'b10,        1'b1,  3, 1'b0,  1, 2'b10, 4'b0010};
        vecs[4] = '{BTYPE_STORED, 1'b0,  1, 1'b1,  3, 2'b01, 4'b0001};
        vecs[5] = '{BTYPE_FIXED,  1'b0,  2, 1'b0, -1, 2'b00, 4'b0100};

        bus_reset = 1'b1;
        desc_valid = 1'b0; desc_btype = 2'b0; desc_rev_endian = 1'b0; desc_words = 24'd0;
        abort = 1'b0; in_valid = 1'b0; core_in_full = 1'b0; sts_ready = 1'b0;
        core_status = 3'b0; core_isize = 32'h0; core_crc = 32'h0; core_out_bits = 24'h0;
        tick();
        tick();
        bus_reset = 1'b0;
        chk("reset_ctrl", 64'({desc_ready, in_ready, core_in_wren, core_rst_n, core_btype,
                                core_rev_endian, busy, sts_valid, irq, sts_err}), 64'd0);
        chk("reset_sts", {sts_isize, sts_crc}, 64'd0);
        chk("reset_out_bits", 64'(sts_out_bits), 64'd0);
        tick();
        chk("idle_ready_after_reset", 64'({desc_ready, busy}), 64'b10);

        // abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", 64'({busy, sts_valid, desc_ready}), 64'b001);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // abort on the cycle of the 3rd FEED transfer
        core_isize = 32'h0000_0ABC;
        start_job(BTYPE_FIXED, 1'b0, 8, wb);
        feed_until(wb, 2, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_capture", 64'({sts_valid, sts_err}), 64'h18);
        chk("abort_xfer_done", 64'(writes - wb), 64'd3);
        ai = sts_isize;
        chk("abort_isize", 64'(ai), 64'h0ABC);
        for (int k = 0; k < 10; k++) begin
            core_isize = $urandom;
            core_status = 3'(k);
            tick();
            chk("abort_hold", {sts_valid, busy, desc_ready, sts_err, 25'd0, sts_isize},
                {1'b1, 1'b1, 1'b0, 4'b1000, 25'd0, ai});
        end
        chk("no_feed_in_report", 64'(writes - wb), 64'd3);
        core_status = 3'b0;
        sts_ready = 1'b1;
        tick();
        sts_ready = 1'b0;
        chk("abort_release", 64'({sts_valid, busy, desc_ready}), 64'b001);

        // bus reset in the middle of DRAIN
        start_job(BTYPE_STORED, 1'b1, 1, wb);
        feed_until(wb, 1, 1'b0);
        tick();
        tick();
        bus_reset = 1'b1;
        tick();
        bus_reset = 1'b0;
        chk("midjob_reset", 64'({busy, core_rst_n, sts_valid, irq, desc_ready, in_ready}), 64'd0);
        tick();
        chk("midjob_reset_idle", 64'({desc_ready, sts_valid}), 64'b10);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", errs);
        $fatal(1, "watchdog expired");
    end

endmodule
